cpu_instr_mem_responder: RTL and testbench

//  Memory-side responder for the cpu_top instruction-fetch port (cpu_read_valid/addr -> cpu_read_data/ack).

---
 rtl/cpu_instr_mem_responder_pkg.sv | 12 +
 rtl/cpu_instr_mem_responder_ram.sv | 33 +++
 rtl/cpu_instr_mem_responder.sv | 102 ++++++++++
 tb/tb_cpu_instr_mem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_instr_mem_responder_pkg.sv
// cpu_instr_mem_responder_pkg: shared defaults, FSM state type and address layout for the fetch responder
package cpu_instr_mem_responder_pkg;

    localparam int DATA_W_DEF     = 128;
    localparam int ADDR_W_DEF     = 33;
    localparam int DEPTH_LOG2_DEF = 8;
    localparam int LATENCY_DEF    = 4;
    localparam int WORD_SHIFT     = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} resp_state_t;

endpackage

// File: rtl/cpu_instr_mem_responder_ram.sv
// instr_ram_1r1w: DEPTH x DATA_W instruction RAM, sync write, registered read, write-first on collision
//  clk    in   clock
//  we     in   write strobe
//  waddr  in   write word index
//  wdata  in   write data
//  re     in   read strobe, rdata updates only when high
//  raddr  in   read word index
//  rdata  out  registered read data
module instr_ram_1r1w
    import cpu_instr_mem_responder_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/cpu_instr_mem_responder.sv
// cpu_instr_mem_responder: fixed-latency instruction-fetch responder with a preloadable 128-bit RAM
//  clk             in   clock, rising edge
//  rst_n           in   asynchronous active-low reset
//  cpu_read_valid  in   fetch request, held until ack
//  cpu_read_addr   in   byte address, word index = addr[WORD_SHIFT+DEPTH_LOG2-1:WORD_SHIFT]
//  cpu_read_data   out  fetched word while ack is high, else 0
//  cpu_read_ack    out  one-cycle response strobe
//  flush           in   abort a fetch still waiting for its response
//  load_en         in   preload write strobe
//  load_addr       in   preload word index
//  load_data       in   preload data
//  addr_err        out  sticky misaligned / out-of-range fetch flag
//  fetch_cnt       out  number of acks issued, wrapping
module cpu_instr_mem_responder
    import cpu_instr_mem_responder_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_read_valid,
    input  logic [ADDR_W-1:0]     cpu_read_addr,
    output logic [DATA_W-1:0]     cpu_read_data,
    output logic                  cpu_read_ack,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  addr_err,
    output logic [31:0]           fetch_cnt
);

    localparam int IDX_HI = WORD_SHIFT + DEPTH_LOG2;

    resp_state_t           state;
    logic [3:0]            lat_cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  take;
    logic                  enter_resp;
    logic                  bad_addr;

    assign req_idx    = cpu_read_addr[IDX_HI-1:WORD_SHIFT];
    assign bad_addr   = |cpu_read_addr[WORD_SHIFT-1:0] || |cpu_read_addr[ADDR_W-1:IDX_HI];
    // flush beats a request arriving on the same edge
    assign take       = state == IDLE && cpu_read_valid && !flush;
    assign enter_resp = (take && LATENCY == 1) || (state == WAIT && lat_cnt == 4'd1 && !flush);
    // with LATENCY=1 the RAM is read on the sampling edge, before idx_q holds the index
    assign rd_addr    = state == IDLE ? req_idx : idx_q;
    assign cpu_read_data = cpu_read_ack ? rd_data : '0;

    instr_ram_1r1w #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (enter_resp),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            idx_q        <= '0;
            cpu_read_ack <= 1'b0;
            addr_err     <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            cpu_read_ack <= enter_resp;
            if (enter_resp)
                fetch_cnt <= fetch_cnt + 32'd1;
            case (state)
                IDLE: if (take) begin
                    idx_q    <= req_idx;
                    lat_cnt  <= 4'(LATENCY - 1);
                    addr_err <= addr_err | bad_addr;
                    state    <= LATENCY == 1 ? RESP : WAIT;
                end
                WAIT: if (flush) begin
                    state <= IDLE;
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                    state   <= lat_cnt == 4'd1 ? RESP : WAIT;
                end
                // the response is committed once RESP is entered, flush cannot cancel it
                RESP: state <= GAP;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_instr_mem_responder.sv
// tb_cpu_instr_mem_responder: scoreboard bench running the fetch suite on LATENCY=4 and LATENCY=1 instances
module tb_cpu_instr_mem_responder;

    typedef struct {
        logic [127:0] data;
        logic [31:0]  cnt;
        int           cyc;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    logic         load_en = 1'b0;
    logic         sel = 1'b0;
    logic [32:0]  addr = '0;
    logic [7:0]   load_addr = '0;
    logic [127:0] load_data = '0;
    logic [127:0] data4, data1, data_m;
    logic         ack4, ack1, ack_m, err4, err1, err_m;
    logic [31:0]  cnt4, cnt1, cnt_m;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   lat = 4;
    int   exp_cnt = 0;
    logic exp_err = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_instr_mem_responder #(.LATENCY(4)) u4 (
        .clk(clk), .rst_n(rst_n), .cpu_read_valid(valid & ~sel), .cpu_read_addr(addr),
        .cpu_read_data(data4), .cpu_read_ack(ack4), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .addr_err(err4), .fetch_cnt(cnt4)
    );

    cpu_instr_mem_responder #(.LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cpu_read_valid(valid & sel), .cpu_read_addr(addr),
        .cpu_read_data(data1), .cpu_read_ack(ack1), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .addr_err(err1), .fetch_cnt(cnt1)
    );

    assign data_m = sel ? data1 : data4;
    assign ack_m  = sel ? ack1 : ack4;
    assign err_m  = sel ? err1 : err4;
    assign cnt_m  = sel ? cnt1 : cnt4;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s (lat=%0d): got %0h expected %0h", name, lat, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && ack_m) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", ack_m, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_data", data_m, mon_e.data);
                chk("fetch_cnt", cnt_m, mon_e.cnt);
                chk("ack_cycle", cyc, mon_e.cyc);
                chk("addr_err", err_m, mon_e.err);
            end
        end else if (rst_n) begin
            chk("idle_data_zero", data_m, 0);
        end
    end

    task automatic load(input int idx, input logic [127:0] d);
        @(negedge clk);
        load_en = 1'b1;
        load_addr = idx[7:0];
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [32:0] a, input logic [127:0] d, input bit col);
        exp_t e;
        bit seen = 0;
        @(negedge clk);
        valid = 1'b1;
        addr = a;
        if (a[3:0] != 0 || a[32:12] != 0)
            exp_err = 1'b1;
        exp_cnt++;
        e.data = d;
        e.cnt = exp_cnt;
        e.cyc = cyc + lat;
        e.err = exp_err;
        sb.push_back(e);
        if (col) begin
            repeat (lat - 1) @(negedge clk);
            load_en = 1'b1;
            load_addr = a[11:4];
            load_data = d;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            load_en = 1'b0;
            seen = ack_m;
        end
        if (!seen) begin
            chk("ack_timeout", seen, 1);
            if (sb.size() > 0)
                void'(sb.pop_back());
        end
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_suite();
        // reset with a preload landing during reset
        @(negedge clk);
        rst_n = 1'b0;
        load_en = 1'b1;
        load_addr = 8'd0;
        load_data = 128'hA000_0000_0000_0000_0000_0D00_0000_0011;
        #1;
        chk("rst_ack", ack_m, 0);
        chk("rst_data", data_m, 0);
        chk("rst_cnt", cnt_m, 0);
        chk("rst_err", err_m, 0);
        @(negedge clk);
        load_en = 1'b0;
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
        fetch(33'h0, 128'hA000_0000_0000_0000_0000_0D00_0000_0011, 0);
        // back-to-back fetches
        for (int i = 0; i < 4; i++)
            load(i, 128'(i + 1));
        load(5, 128'h55);
        for (int i = 0; i < 4; i++)
            fetch(33'(i * 16), 128'(i + 1), 0);
        // bad addresses still ack, addr_err sticks
        fetch(33'h1_0000_0010, 128'h2, 0);
        fetch(33'h20, 128'h3, 0);
        fetch(33'h31, 128'h4, 0);
        // flush together with a new request: not sampled
        @(negedge clk);
        valid = 1'b1;
        addr = 33'h0;
        flush = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        repeat (lat + 3) @(negedge clk);
        chk("flush_same_edge_cnt", cnt_m, exp_cnt);
        // flush two cycles into the wait
        if (lat > 2) begin
            @(negedge clk);
            valid = 1'b1;
            addr = 33'h0;
            repeat (2) @(negedge clk);
            flush = 1'b1;
            valid = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            repeat (8) @(negedge clk);
            chk("flush_wait_cnt", cnt_m, exp_cnt);
        end
        fetch(33'h10, 128'h2, 0);
        // write-first collision on the response-entry edge
        fetch(33'h50, 128'hBEEF, 1);
        // async reset in the middle of a wait; RAM survives
        if (lat > 2) begin
            @(negedge clk);
            valid = 1'b1;
            addr = 33'h20;
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("async_rst_ack", ack_m, 0);
            chk("async_rst_data", data_m, 0);
            chk("async_rst_cnt", cnt_m, 0);
            chk("async_rst_err", err_m, 0);
            valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            exp_cnt = 0;
            exp_err = 1'b0;
            fetch(33'h30, 128'h4, 0);
            fetch(33'h50, 128'hBEEF, 0);
        end
    endtask

    initial begin
        sel = 1'b0;
        lat = 4;
        run_suite();
        sel = 1'b1;
        lat = 1;
        run_suite();
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
